// File: rtl/cadence_meas.sv
// Cadence period meter: times consecutive filtered pedal rises in prescaled ticks
// and reports the latest period, a 4-sample floor average and a not-pedaling flag.
module cadence_meas #(
    parameter int unsigned FAST_SIM     = 0,
    parameter int unsigned PRESC_W      = 10,
    parameter int unsigned PRESC_W_FAST = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned MIN_PER      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cadence_rise,
    output logic [CNT_W-1:0] cadence_per,
    output logic [CNT_W-1:0] cadence_avg,
    output logic             cadence_vld,
    output logic             not_pedaling
);

    localparam int unsigned PW    = (FAST_SIM != 0) ? PRESC_W_FAST : PRESC_W;
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic [CNT_W-1:0]      per_q, per_d;
    logic [CNT_W-1:0]      cper_q, cper_d;
    logic [3:0][CNT_W-1:0] hist_q, hist_d;
    logic                  vld_q, vld_d;
    logic                  np_q, np_d;

    logic                  tick_c;
    logic                  sat_c;
    logic                  accept_c;
    logic [CNT_W-1:0]      cap_c;
    logic [SUM_W-1:0]      sum_c;

    // A tick on the capture edge is still counted, saturating at MAX.
    always_comb begin
        tick_c   = (pre_q == {PW{1'b1}});
        cap_c    = (per_q == MAX) ? MAX : per_q + CNT_W'(tick_c);
        sat_c    = tick_c && (per_q == MAX - CNT_W'(1));
        accept_c = cadence_rise && ((state_q == ST_STOPPED) || (cap_c >= CNT_W'(MIN_PER)));
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q + PW'(1);
        per_d   = (tick_c && (per_q != MAX)) ? per_q + CNT_W'(1) : per_q;
        cper_d  = cper_q;
        hist_d  = hist_q;
        vld_d   = 1'b0;

        if (accept_c) begin
            pre_d = '0;
            per_d = '0;
        end

        // An accepted rise takes priority over a same-edge saturation.
        case (state_q)
            ST_STOPPED: begin
                if (accept_c) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (accept_c) begin
                    cper_d  = cap_c;
                    hist_d  = {4{cap_c}};
                    vld_d   = 1'b1;
                    state_d = ST_RUN;
                end else if (sat_c) begin
                    state_d = ST_STOPPED;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    cper_d = cap_c;
                    hist_d = {hist_q[2:0], cap_c};
                    vld_d  = 1'b1;
                end else if (sat_c) begin
                    state_d = ST_STOPPED;
                    cper_d  = MAX;
                    hist_d  = {4{MAX}};
                end
            end
            default: state_d = ST_STOPPED;
        endcase

        np_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOPPED;
            pre_q   <= '0;
            per_q   <= '0;
            cper_q  <= MAX;
            hist_q  <= {4{MAX}};
            vld_q   <= 1'b0;
            np_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            per_q   <= per_d;
            cper_q  <= cper_d;
            hist_q  <= hist_d;
            vld_q   <= vld_d;
            np_q    <= np_d;
        end
    end

    // Average tracks the history registers directly, so it is ready with the strobe.
    always_comb begin
        sum_c = SUM_W'(hist_q[0]) + SUM_W'(hist_q[1]) + SUM_W'(hist_q[2]) + SUM_W'(hist_q[3]);
    end

    assign cadence_avg  = sum_c[SUM_W-1:2];
    assign cadence_per  = cper_q;
    assign cadence_vld  = vld_q;
    assign not_pedaling = np_q;

endmodule

// File: tb/tb_cadence_meas.sv
// Scoreboard bench for cadence_meas in fast-sim mode (tick every 16 clk).
module tb_cadence_meas;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cadence_rise;
    logic [CNT_W-1:0] cadence_per;
    logic [CNT_W-1:0] cadence_avg;
    logic             cadence_vld;
    logic             not_pedaling;

    typedef struct packed {
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] avg;
        logic             np;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    cadence_meas #(
        .FAST_SIM    (1),
        .PRESC_W     (10),
        .PRESC_W_FAST(4),
        .CNT_W       (CNT_W),
        .MIN_PER     (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cadence_rise(cadence_rise),
        .cadence_per (cadence_per),
        .cadence_avg (cadence_avg),
        .cadence_vld (cadence_vld),
        .not_pedaling(not_pedaling)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the rise is sampled by the following posedge.
    task automatic do_rise();
        cadence_rise = 1'b1;
        @(negedge clk);
        cadence_rise = 1'b0;
    endtask

    task automatic push_exp(input int per, input int avg);
        exp_t e;
        e.per = CNT_W'(per);
        e.avg = CNT_W'(avg);
        e.np  = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_per"}, 32'(cadence_per), 32'd255);
        chk({tag, "_avg"}, 32'(cadence_avg), 32'd255);
        chk({tag, "_np"},  32'(not_pedaling), 32'd1);
        chk({tag, "_vld"}, 32'(cadence_vld), 32'd0);
    endtask

    initial begin
        exp_t e;
        rst_n        = 1'b0;
        cadence_rise = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (cadence_vld === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_vld: got vld=1 with per=%0d avg=%0d, expected no strobe (t=%0t)",
                                 cadence_per, cadence_avg, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("vld_per", 32'(cadence_per), 32'(e.per));
                        chk("vld_avg", 32'(cadence_avg), 32'(e.avg));
                        chk("vld_np",  32'(not_pedaling), 32'(e.np));
                    end
                end
            end
        join_none

        // Reset state
        gap(3);
        #1 chk_idle("in_reset");
        gap(2);
        rst_n = 1'b1;
        gap(5);
        chk_idle("post_reset");

        // First period: rise arms only, the next one 320 clk later captures 20
        do_rise();
        gap(20);
        chk("armed_np", 32'(not_pedaling), 32'd1);
        gap(319 - 20);
        push_exp(20, 20);
        do_rise();
        gap(2);
        chk("first_np",  32'(not_pedaling), 32'd0);
        chk("first_per", 32'(cadence_per), 32'd20);

        // Running average over 320, 320, 640, then 330 (floor to 20 ticks)
        gap(318); push_exp(20, 20); do_rise();
        gap(319); push_exp(20, 20); do_rise();
        gap(639); push_exp(40, 25); do_rise();
        gap(329); push_exp(20, 25); do_rise();

        // Bounce 10 clk after an accepted rise is ignored entirely
        gap(9);
        do_rise();
        gap(3);
        chk("bounce_per", 32'(cadence_per), 32'd20);
        chk("bounce_avg", 32'(cadence_avg), 32'd25);
        chk("bounce_np",  32'(not_pedaling), 32'd0);
        gap(309 - 3);
        push_exp(20, 25);
        do_rise();

        // Timeout: 4080 clk with no rise drops back to stopped
        gap(4100);
        chk_idle("timeout");
        do_rise();
        gap(20);
        chk("rearm_np",  32'(not_pedaling), 32'd1);
        chk("rearm_per", 32'(cadence_per), 32'd255);
        gap(299);
        push_exp(20, 20);
        do_rise();
        gap(319);
        push_exp(20, 20);
        do_rise();

        // Reset asserted one cycle after the strobe
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_idle("mid_reset");
        gap(3);
        rst_n = 1'b1;
        gap(3);
        do_rise();
        gap(20);
        chk_idle("reset_rearm");
        gap(299);
        push_exp(20, 20);
        do_rise();

        gap(10);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cadence_meas.md
Name: cadence_meas

Overview:
- Downstream consumer of the cadence filter stage; takes its one-clock `cadence_rise` pulse and measures the time between consecutive pedal-sensor rising edges.
- Measures in prescaled ticks and outputs the latest period, a 4-sample running average and a not-pedaling flag.
- Outputs feed the cadence lookup and the assist computation.

Parameters:
FAST_SIM, 0, 1 selects short prescaler for simulation
PRESC_W, 10, prescaler width in normal mode (tick every 2^PRESC_W clk)
PRESC_W_FAST, 4, prescaler width when FAST_SIM=1
CNT_W, 8, period counter / output width
MIN_PER, 2, minimum accepted period in ticks; faster rises are rejected as bounce

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
cadence_rise  in  1  one-clk pulse per filtered cadence rising edge
cadence_per  out  CNT_W  last captured period in ticks; all-ones = stopped
cadence_avg  out  CNT_W  floor mean of last 4 captured periods
cadence_vld  out  1  one-clk strobe: cadence_per/cadence_avg just updated
not_pedaling  out  1  high when no valid period is available

Behaviour:
- Reset: async, rst_n=0. Effects:
  - State=STOPPED; pre_cnt=0; per_cnt=0.
  - 4-entry history all-ones.
  - cadence_per=all-ones, cadence_avg=all-ones, cadence_vld=0, not_pedaling=1.
- Prescaler: pre_cnt, width PW = FAST_SIM ? PRESC_W_FAST : PRESC_W.
  - tick = (pre_cnt == 2^PW-1), combinational.
  - Increments every clk and wraps on tick.
- Period counter: per_cnt, CNT_W bits.
  - Increments on tick; saturates at MAX = 2^CNT_W-1.
- Capture value: cap = per_cnt + tick, saturating at MAX. A same-cycle tick is counted.
- Accepted rise: cadence_rise=1 and cap >= MIN_PER.
  - On the edge: pre_cnt←0, per_cnt←0.
  - Rejected rise: no effect at all; counters continue.
- Exception: in STOPPED every cadence_rise is accepted (MIN_PER not checked).
- FSM:
  - STOPPED:
    - not_pedaling=1.
    - rise → clear counters → ARMED. No capture, no vld.
  - ARMED:
    - not_pedaling=1.
    - Accepted rise → cadence_per←cap, all 4 history entries←cap, cadence_vld=1 next cycle → RUN.
    - per_cnt reaches MAX (edge where per_cnt==MAX-1 and tick) → STOPPED.
  - RUN:
    - not_pedaling=0.
    - Accepted rise → cadence_per←cap, history shifts in cap (oldest dropped), cadence_vld=1 next cycle.
    - Saturation → STOPPED. On the same edge: cadence_per←MAX, history←all MAX, not_pedaling←1. No vld.
- Simultaneous accepted rise and saturating tick: rise wins. Captures cap=MAX and stays/goes per rise rule.
- cadence_avg:
  - Sum of 4 history entries, CNT_W+2 bits, >>2 (floor).
  - Combinational from history registers, so valid in the same cycle as cadence_vld.
- Latency: rise at edge N → cadence_per, history, not_pedaling updated at edge N+1; cadence_vld high for exactly the cycle after N+1. Equivalently: outputs visible and vld=1 in cycle N+1.
- cadence_per and cadence_avg hold between captures.
- Registered outputs: cadence_per, cadence_vld, not_pedaling.
- Reset asserted mid-operation: immediate return to reset values; any capture in progress is lost.

Test Plan:
All cases use FAST_SIM=1 (tick every 16 clk), CNT_W=8, MIN_PER=2.
1. Reset: hold rst_n=0, then release with no rise → cadence_per=255, cadence_avg=255, not_pedaling=1, cadence_vld never asserted.
2. First period: rises 320 clk apart → first rise gives no vld, state ARMED; second gives cadence_vld one cycle, cadence_per=20, cadence_avg=20, not_pedaling=0.
3. Average: continue with spacings 320, 320, 640 → final cadence_per=40, cadence_avg=(40+20+20+20)/4=25. Spacing 330 → cadence_per=20 (floor of ticks).
4. Timeout: after a RUN capture, no rise for 255*16=4080 clk → not_pedaling=1, cadence_per=255, cadence_avg=255, no vld. A next rise → ARMED only.
5. Bounce: in RUN, second rise 10 clk after an accepted rise (cap=0 <2) → no vld, outputs unchanged. The next rise 320 clk after the accepted one → cadence_per=20.
6. Reset mid-RUN: assert rst_n=0 one cycle after a cadence_vld → outputs immediately 255/255/1/0. The first rise after release → ARMED, no vld.
